// File: rtl/baby_mem_responder.sv
// Memory-side responder: moves one 32-bit word as four byte beats over a four-phase
// req/ack bus, little-endian, aborting a beat that stalls for TIMEOUT cycles.
module baby_mem_responder #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [4:0]  ram_addr_i,
  input  logic        ram_rw_en_i,
  input  logic [31:0] ram_data_i,
  output logic [31:0] ram_data_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        ext_req_o,
  input  logic        ext_ack_i,
  output logic        ext_we_o,
  output logic [6:0]  ext_addr_o,
  output logic [7:0]  ext_data_o,
  input  logic [7:0]  ext_data_i
);

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StReq, StRelease, StDone} state_e;

  state_e      state_q, state_d;
  logic [4:0]  addr_q, addr_d;
  logic        rw_q, rw_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] shadow_q, shadow_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  lane_q, lane_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        timed_out;
  logic        active;

  // This waiting cycle is the TIMEOUT-th one spent in the current phase.
  assign timed_out = (cnt_q + 8'd1) == TimeoutCnt;
  assign active    = (state_q == StReq) || (state_q == StRelease);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rw_d     = rw_q;
    wdata_d  = wdata_q;
    shadow_d = shadow_q;
    rdata_d  = rdata_q;
    lane_d   = lane_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          addr_d  = ram_addr_i;
          rw_d    = ram_rw_en_i;
          wdata_d = ram_data_i;
          lane_d  = 2'd0;
          cnt_d   = 8'd0;
          err_d   = 1'b0;
          state_d = StReq;
        end
      end
      StReq: begin
        // An ack always wins over a timeout landing in the same cycle.
        if (ext_ack_i) begin
          if (!rw_q) shadow_d[8*lane_q +: 8] = ext_data_i;
          cnt_d   = 8'd0;
          state_d = StRelease;
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StRelease: begin
        if (!ext_ack_i) begin
          cnt_d = 8'd0;
          if (lane_q == 2'd3) begin
            state_d = StDone;
          end else begin
            lane_d  = lane_q + 2'd1;
            state_d = StReq;
          end
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone: begin
        if (!rw_q && !err_q) rdata_d = shadow_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset_i) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      rw_q     <= 1'b0;
      wdata_q  <= '0;
      shadow_q <= '0;
      rdata_q  <= '0;
      lane_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rw_q     <= rw_d;
      wdata_q  <= wdata_d;
      shadow_q <= shadow_d;
      rdata_q  <= rdata_d;
      lane_q   <= lane_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    ram_data_o = rdata_q;
    busy_o     = state_q != StIdle;
    done_o     = state_q == StDone;
    err_o      = (state_q == StDone) && err_q;
    ext_req_o  = state_q == StReq;
    ext_we_o   = 1'b0;
    ext_addr_o = '0;
    ext_data_o = '0;
    if (active) begin
      ext_we_o   = rw_q;
      ext_addr_o = {addr_q, lane_q};
      if (rw_q) ext_data_o = wdata_q[8*lane_q +: 8];
    end
  end

endmodule

// File: tb/tb_baby_mem_responder.sv
// Self-checking bench: a reactive byte-memory slave with per-phase ack delays, checked
// against a phase-timing model and a reference byte memory.
module tb_baby_mem_responder;
  localparam int T = 4;

  logic        clock = 1'b0;
  logic        reset_i, start_i, ram_rw_en_i, ext_ack_i;
  logic [4:0]  ram_addr_i;
  logic [31:0] ram_data_i, ram_data_o;
  logic        busy_o, done_o, err_o, ext_req_o, ext_we_o;
  logic [6:0]  ext_addr_o;
  logic [7:0]  ext_data_o, ext_data_i;

  int vectors = 0, miscompares = 0;

  logic [7:0]  mem     [128];
  logic [7:0]  ref_mem [128];
  logic [31:0] exp_rdata;
  int          req_dly [4];
  int          rel_dly [4];
  int          extra_start[$];
  int          rst_cyc = -1;

  int          obs_done_cyc, obs_beats, obs_proto, obs_busy_bad, obs_post;
  logic        obs_err, obs_busy_after, obs_rst_req, obs_rst_busy, rst_hit;
  logic [31:0] obs_rdata_after;
  logic [6:0]  obs_addr[$];
  logic [7:0]  obs_wdata[$];
  logic        obs_we[$];

  always #5 clock = ~clock;

  baby_mem_responder #(.TIMEOUT(T)) dut (
    .clock(clock), .reset_i(reset_i), .start_i(start_i), .ram_addr_i(ram_addr_i),
    .ram_rw_en_i(ram_rw_en_i), .ram_data_i(ram_data_i), .ram_data_o(ram_data_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .ext_req_o(ext_req_o),
    .ext_ack_i(ext_ack_i), .ext_we_o(ext_we_o), .ext_addr_o(ext_addr_o),
    .ext_data_o(ext_data_o), .ext_data_i(ext_data_i)
  );

  task automatic set_delays(input int rq, input int rl);
    for (int i = 0; i < 4; i++) begin
      req_dly[i] = rq;
      rel_dly[i] = rl;
    end
  endtask

  // Phase-level model: a phase with delay d lasts d+1 cycles, or aborts after T cycles if d >= T.
  function automatic void predict(output logic e, output int c, output int acked,
                                  output int beats);
    c = 1; e = 1'b0; acked = 0; beats = 0;
    for (int l = 0; l < 4; l++) begin
      beats++;
      if (req_dly[l] >= T) begin c += T; e = 1'b1; return; end
      c += req_dly[l] + 1;
      acked++;
      if (rel_dly[l] >= T) begin c += T; e = 1'b1; return; end
      c += rel_dly[l] + 1;
    end
  endfunction

  // Issues one access and plays the external memory, recording what the DUT did.
  task automatic run_xfer(input logic [4:0] a, input logic rw, input logic [31:0] wd);
    int   cyc, cnt, rcnt, lane;
    logic prev_req, prev_ack, stop;
    obs_done_cyc = -1; obs_beats = 0; obs_proto = 0; obs_busy_bad = 0; obs_post = 0;
    obs_err = 1'bx; rst_hit = 1'b0;
    obs_addr.delete(); obs_wdata.delete(); obs_we.delete();
    @(negedge clock);
    ext_ack_i = 1'b0; start_i = 1'b1; ram_addr_i = a; ram_rw_en_i = rw; ram_data_i = wd;
    cyc = 0; cnt = 0; rcnt = 0; lane = 0; prev_req = 1'b0; stop = 1'b0;
    while (cyc < 400 && !stop) begin
      @(negedge clock);
      cyc++;
      start_i = 1'b0;
      foreach (extra_start[i]) begin
        if (extra_start[i] == cyc) begin
          start_i = 1'b1; ram_addr_i = 5'($urandom); ram_rw_en_i = ~rw; ram_data_i = $urandom;
        end
      end
      if (cyc == rst_cyc) begin
        obs_rst_req = ext_req_o; obs_rst_busy = busy_o;
        reset_i = 1'b1; ext_ack_i = 1'b0; start_i = 1'b0;
        rst_hit = 1'b1; stop = 1'b1;
      end else begin
        prev_ack = ext_ack_i;
        if (!busy_o) obs_busy_bad++;
        if (ext_req_o && !prev_req) begin
          if (prev_ack) obs_proto++;
          lane = (obs_beats > 3) ? 3 : obs_beats;
          obs_beats++;
          cnt = 0;
        end
        if (!ext_req_o && prev_req) begin
          if (!prev_ack && !(done_o && err_o)) obs_proto++;
          rcnt = 0;
        end
        if (ext_req_o) begin
          if (!ext_ack_i) begin
            if (cnt >= req_dly[lane]) begin
              ext_ack_i = 1'b1;
              obs_addr.push_back(ext_addr_o);
              obs_we.push_back(ext_we_o);
              obs_wdata.push_back(ext_data_o);
              if (ext_we_o) mem[ext_addr_o] = ext_data_o;
              ext_data_i = mem[ext_addr_o];
            end else cnt++;
          end
        end else if (ext_ack_i) begin
          if (rcnt >= rel_dly[lane]) begin
            ext_ack_i = 1'b0; ext_data_i = 8'($urandom);
          end else rcnt++;
        end
        if (done_o) begin obs_done_cyc = cyc; obs_err = err_o; stop = 1'b1; end
        prev_req = ext_req_o;
      end
    end
    if (!stop) begin
      vectors++; miscompares++;
      $display("FAIL xfer_timeout: no done_o within 400 cycles, want one");
    end
    if (!rst_hit) begin
      ext_ack_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clock);
        if (k == 0) begin obs_rdata_after = ram_data_o; obs_busy_after = busy_o; end
        if (done_o || ext_req_o) obs_post++;
      end
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1; start_i = 1'b0; ext_ack_i = 1'b0;
    repeat (2) @(negedge clock);
    vectors++;
    if ({ram_data_o, busy_o, done_o, err_o, ext_req_o, ext_we_o, ext_addr_o, ext_data_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got data=%h busy=%b done=%b req=%b addr=%h, want all 0",
               ram_data_o, busy_o, done_o, ext_req_o, ext_addr_o);
    end
    reset_i = 1'b0;
    exp_rdata = '0;
  endtask

  task automatic test_read();
    logic [7:0] bytes [4];
    bytes[0] = 8'h78; bytes[1] = 8'h56; bytes[2] = 8'h34; bytes[3] = 8'h12;
    for (int i = 0; i < 4; i++) begin mem[7'h28 + i] = bytes[i]; ref_mem[7'h28 + i] = bytes[i]; end
    set_delays(1, 1);
    run_xfer(5'h0A, 1'b0, 32'h0);
    exp_rdata = 32'h12345678;
    vectors++; if (obs_done_cyc !== 17) begin miscompares++;
      $display("FAIL read_done_cycle: got %0d want 17", obs_done_cyc); end
    vectors++; if (obs_err !== 1'b0) begin miscompares++;
      $display("FAIL read_err: got %b want 0", obs_err); end
    vectors++; if (obs_rdata_after !== exp_rdata) begin miscompares++;
      $display("FAIL read_data: got %h want %h", obs_rdata_after, exp_rdata); end
    vectors++; if (obs_addr.size() !== 4) begin miscompares++;
      $display("FAIL read_beats: got %0d want 4", obs_addr.size()); end
    for (int i = 0; i < obs_addr.size() && i < 4; i++) begin
      vectors++;
      if (obs_addr[i] !== 7'(8'h28 + i) || obs_we[i] !== 1'b0 || obs_wdata[i] !== 8'h00) begin
        miscompares++;
        $display("FAIL read_beat%0d: got addr=%h we=%b data=%h want addr=%h we=0 data=00",
                 i, obs_addr[i], obs_we[i], obs_wdata[i], 7'(8'h28 + i));
      end
    end
    vectors++; if (obs_proto !== 0 || obs_busy_bad !== 0 || obs_busy_after !== 1'b0) begin
      miscompares++;
      $display("FAIL read_handshake: got proto=%0d busy_gaps=%0d busy_after=%b want 0,0,0",
               obs_proto, obs_busy_bad, obs_busy_after); end
  endtask

  task automatic test_write();
    logic [7:0] bytes [4];
    bytes[0] = 8'hEF; bytes[1] = 8'hBE; bytes[2] = 8'hAD; bytes[3] = 8'hDE;
    set_delays(1, 1);
    run_xfer(5'h1F, 1'b1, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) ref_mem[7'h7C + i] = bytes[i];
    vectors++; if (obs_done_cyc !== 17 || obs_err !== 1'b0) begin miscompares++;
      $display("FAIL write_done: got cycle=%0d err=%b want 17,0", obs_done_cyc, obs_err); end
    vectors++; if (obs_addr.size() !== 4) begin miscompares++;
      $display("FAIL write_beats: got %0d want 4", obs_addr.size()); end
    for (int i = 0; i < obs_addr.size() && i < 4; i++) begin
      vectors++;
      if (obs_addr[i] !== 7'(8'h7C + i) || obs_we[i] !== 1'b1 || obs_wdata[i] !== bytes[i]) begin
        miscompares++;
        $display("FAIL write_beat%0d: got addr=%h we=%b data=%h want addr=%h we=1 data=%h",
                 i, obs_addr[i], obs_we[i], obs_wdata[i], 7'(8'h7C + i), bytes[i]);
      end
    end
    vectors++; if (obs_rdata_after !== exp_rdata) begin miscompares++;
      $display("FAIL write_keeps_rdata: got %h want %h", obs_rdata_after, exp_rdata); end
  endtask

  task automatic test_busy_start();
    set_delays(1, 1);
    extra_start.push_back(3);
    extra_start.push_back(9);
    run_xfer(5'h1F, 1'b0, 32'h0);
    extra_start.delete();
    exp_rdata = 32'hDEADBEEF;
    vectors++; if (obs_beats !== 4 || obs_post !== 0) begin miscompares++;
      $display("FAIL busy_start_beats: got beats=%0d extra=%0d want 4,0", obs_beats, obs_post); end
    vectors++; if (obs_done_cyc !== 17 || obs_rdata_after !== exp_rdata) begin miscompares++;
      $display("FAIL busy_start_result: got cycle=%0d data=%h want 17,%h",
               obs_done_cyc, obs_rdata_after, exp_rdata); end
  endtask

  task automatic test_timeout();
    set_delays(1, 1);
    req_dly[2] = 1000;
    run_xfer(5'h0A, 1'b0, 32'h0);
    vectors++; if (obs_done_cyc !== 13 || obs_err !== 1'b1) begin miscompares++;
      $display("FAIL timeout_done: got cycle=%0d err=%b want 13,1", obs_done_cyc, obs_err); end
    vectors++; if (obs_beats !== 3 || obs_rdata_after !== exp_rdata) begin miscompares++;
      $display("FAIL timeout_effect: got beats=%0d data=%h want 3,%h",
               obs_beats, obs_rdata_after, exp_rdata); end
    set_delays(1, 1);
    run_xfer(5'h0A, 1'b0, 32'h0);
    exp_rdata = 32'h12345678;
    vectors++; if (obs_done_cyc !== 17 || obs_err !== 1'b0 || obs_rdata_after !== exp_rdata) begin
      miscompares++;
      $display("FAIL timeout_recover: got cycle=%0d err=%b data=%h want 17,0,%h",
               obs_done_cyc, obs_err, obs_rdata_after, exp_rdata); end
  endtask

  task automatic test_reset_mid();
    set_delays(1, 1);
    rst_cyc = 7;
    run_xfer(5'h0A, 1'b0, 32'h0);
    rst_cyc = -1;
    vectors++; if (rst_hit !== 1'b1 || obs_rst_req !== 1'b0 || obs_rst_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_phase: got hit=%b req=%b busy=%b want 1,0,1",
               rst_hit, obs_rst_req, obs_rst_busy); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      reset_i = 1'b0;
      vectors++;
      if ({ram_data_o, busy_o, done_o, err_o, ext_req_o, ext_we_o, ext_addr_o, ext_data_o} !== '0)
      begin
        miscompares++;
        $display("FAIL reset_mid_outputs%0d: got data=%h busy=%b done=%b req=%b want all 0",
                 k, ram_data_o, busy_o, done_o, ext_req_o);
      end
    end
    exp_rdata = '0;
    run_xfer(5'h1F, 1'b0, 32'h0);
    exp_rdata = 32'hDEADBEEF;
    vectors++; if (obs_done_cyc !== 17 || obs_rdata_after !== exp_rdata) begin miscompares++;
      $display("FAIL reset_mid_recover: got cycle=%0d data=%h want 17,%h",
               obs_done_cyc, obs_rdata_after, exp_rdata); end
  endtask

  task automatic test_random();
    logic [4:0]  a;
    logic        rw, e;
    logic [31:0] wd;
    int          c, acked, beats;
    for (int n = 0; n < 24; n++) begin
      a = 5'($urandom); rw = 1'($urandom_range(0, 1)); wd = $urandom;
      for (int l = 0; l < 4; l++) begin
        req_dly[l] = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 5) : $urandom_range(0, 3);
        rel_dly[l] = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 5) : $urandom_range(0, 3);
      end
      if (n == 0) set_delays(0, 0);
      if (n == 1) set_delays(T - 1, T - 1);
      predict(e, c, acked, beats);
      run_xfer(a, rw, wd);
      if (rw) begin
        for (int i = 0; i < acked; i++) ref_mem[7'(a * 4 + i)] = wd[8*i +: 8];
      end else if (!e) begin
        for (int i = 0; i < 4; i++) exp_rdata[8*i +: 8] = ref_mem[7'(a * 4 + i)];
      end
      vectors++;
      if (obs_done_cyc !== c || obs_err !== e || obs_beats !== beats || obs_addr.size() !== acked)
      begin
        miscompares++;
        $display("FAIL rand%0d_timing: got cycle=%0d err=%b beats=%0d acked=%0d want %0d,%b,%0d,%0d",
                 n, obs_done_cyc, obs_err, obs_beats, obs_addr.size(), c, e, beats, acked);
      end
      for (int i = 0; i < obs_addr.size() && i < 4; i++) begin
        vectors++;
        if (obs_addr[i] !== 7'(a * 4 + i) || obs_we[i] !== rw ||
            obs_wdata[i] !== (rw ? wd[8*i +: 8] : 8'h00)) begin
          miscompares++;
          $display("FAIL rand%0d_beat%0d: got addr=%h we=%b data=%h want addr=%h we=%b",
                   n, i, obs_addr[i], obs_we[i], obs_wdata[i], 7'(a * 4 + i), rw);
        end
      end
      vectors++;
      if (obs_rdata_after !== exp_rdata || obs_proto !== 0 || obs_busy_bad !== 0 ||
          obs_busy_after !== 1'b0 || obs_post !== 0) begin
        miscompares++;
        $display("FAIL rand%0d_result: got data=%h proto=%0d gaps=%0d busy=%b post=%0d want %h,0,0,0,0",
                 n, obs_rdata_after, obs_proto, obs_busy_bad, obs_busy_after, obs_post, exp_rdata);
      end
    end
  endtask

  initial begin
    reset_i = 1'b1; start_i = 1'b0; ram_addr_i = '0; ram_rw_en_i = 1'b0; ram_data_i = '0;
    ext_ack_i = 1'b0; ext_data_i = '0;
    for (int i = 0; i < 128; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_read();
    test_write();
    test_busy_start();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/baby_mem_responder.md
Name: baby_mem_responder

Overview:
- Memory-side responder for the manchester_baby RAM interface: serves one 32-bit word access (read or write, 5-bit word address) per request.
- Moves each word over an 8-bit off-chip byte bus, one byte per beat, with a four-phase req/ack handshake.
- Sits between the CPU core and the chip pins, complementing the ptp_a (8→32) and ptp_b (32→8) packers with the control sequencing they lack.
- Raises busy_o so the top level can hold the CPU clock (clock_o) during a transfer.

Parameters:
- TIMEOUT, 255, max cycles waited in any single handshake phase before abort; 8-bit counter, legal range 1..255.

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset_i  input  1  synchronous, active-high reset
- start_i  input  1  one-cycle access request from CPU side
- ram_addr_i  input  5  word address, sampled on accepted start_i
- ram_rw_en_i  input  1  0 = read, 1 = write; sampled on accepted start_i
- ram_data_i  input  32  write word, sampled on accepted start_i
- ram_data_o  output  32  last successfully read word
- busy_o  output  1  high from cycle after accepted start_i until done_o cycle inclusive
- done_o  output  1  one-cycle completion pulse
- err_o  output  1  one-cycle pulse coincident with done_o on timeout abort
- ext_req_o  output  1  byte-beat request
- ext_ack_i  input  1  byte-beat acknowledge from external memory
- ext_we_o  output  1  beat direction, 1 = write
- ext_addr_o  output  7  {word address[4:0], byte lane[1:0]}
- ext_data_o  output  8  write byte
- ext_data_i  input  8  read byte, valid when ext_ack_i high

Behaviour:
- Reset: every output 0, FSM in IDLE, latched address/data/lane/timeout counter cleared. Reset mid-transfer aborts with no done_o pulse; ram_data_o is cleared.
- start_i is accepted only in IDLE. While busy it is ignored, not queued.
- Accepting start_i latches addr, rw and data, sets lane = 0, and moves the FSM to REQ.
- States: IDLE, REQ, RELEASE, DONE.
- REQ:
  - ext_req_o = 1.
  - ext_addr_o = {addr, lane}; ext_we_o = rw.
  - ext_data_o = latched_data[8*lane+7 : 8*lane], little-endian, lane 0 first. ext_data_o = 0 on reads.
  - On ext_ack_i = 1: for a read, capture ext_data_i into shadow bits [8*lane+7 : 8*lane]. Then go to RELEASE.
- RELEASE:
  - ext_req_o = 0; address, data and we stay stable.
  - On ext_ack_i = 0: if lane = 3, go to DONE; otherwise lane += 1 and go to REQ.
- DONE (1 cycle):
  - done_o = 1, busy_o = 1.
  - On a read, copy shadow into ram_data_o in this cycle; it is visible from the next cycle.
  - Writes leave ram_data_o unchanged.
  - Then go to IDLE.
- Timeout counter:
  - Clears on every REQ/RELEASE state entry and increments each cycle spent waiting.
  - Reaching TIMEOUT in either state forces DONE with err_o = 1.
  - On abort: ext_req_o drops immediately, shadow is discarded, ram_data_o is unchanged.
- Latency with an ack that rises/falls one cycle after req/release: start_i at cycle 0, REQ entered at cycle 1, 2 cycles per phase, done_o at cycle 17.
- In IDLE, ext_addr_o, ext_data_o and ext_we_o are held at 0.
- ext_ack_i already high on entry to REQ counts as an ack in that cycle.

Test Plan:
- Read: ram_addr_i = 5'h0A, rw = 0, external model returns bytes 78,56,34,12 (lanes 0..3) with 1-cycle ack. Required: ext_addr_o sequence 0x28..0x2B; done_o at cycle 17; ram_data_o = 32'h12345678; err_o = 0.
- Write: addr 5'h1F, data 32'hDEADBEEF. Required: ext_we_o = 1; ext_data_o EF,BE,AD,DE on ext_addr_o 0x7C..0x7F; ram_data_o unchanged from the prior read.
- Busy start: start_i pulsed again at cycles 3 and 9 of a transfer. Required: ignored, exactly one done_o, no extra beats.
- Timeout: TIMEOUT = 4, ext_ack_i never asserted on lane 2 of a read. Required: done_o = err_o = 1 four cycles after lane-2 REQ entry; ram_data_o keeps its old value; next start_i works normally.
- Reset mid-read: reset_i asserted during lane 1 RELEASE. Required: next cycle all outputs 0, FSM in IDLE; a following read completes correctly.
- Slow/early ack: variable 0–5 cycle ack delays, including ack already high on REQ entry. Required: correct 32-bit assembly and the four-phase ordering held throughout.
